// File: rtl/timer_io_8.sv
// Memory-mapped 16-bit down-counting timer with 12-bit prescaler, auto-reload,
// W1C status flag and registered interrupt output.
module timer_io_8 (
    input  logic       clk,
    input  logic       reset_,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    input  logic       we,
    output logic [7:0] dout,
    output logic       irq
);

    localparam logic [2:0] ADDR_RELOAD_LO = 3'd0;
    localparam logic [2:0] ADDR_RELOAD_HI = 3'd1;
    localparam logic [2:0] ADDR_COUNT_LO  = 3'd2;
    localparam logic [2:0] ADDR_COUNT_HI  = 3'd3;
    localparam logic [2:0] ADDR_CTRL      = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    logic [15:0] reload_q;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [7:0]  snap_q;
    logic        en_q;
    logic        en_d;
    logic        auto_q;
    logic        ie_q;
    logic        ie_d;
    logic [1:0]  psc_sel_q;
    logic [11:0] pre_q;
    logic [11:0] pre_d;
    logic        flag_q;
    logic        flag_d;
    logic        irq_q;

    logic wr;
    logic rd;
    logic wr_lo;
    logic wr_hi;
    logic wr_ctrl;
    logic wr_stat;
    logic rd_count_lo;
    logic psc_hit;
    logic tick;
    logic expire;

    assign wr          = cs & we;
    assign rd          = cs & ~we;
    assign wr_lo       = wr & (addr == ADDR_RELOAD_LO);
    assign wr_hi       = wr & (addr == ADDR_RELOAD_HI);
    assign wr_ctrl     = wr & (addr == ADDR_CTRL);
    assign wr_stat     = wr & (addr == ADDR_STATUS);
    assign rd_count_lo = rd & (addr == ADDR_COUNT_LO);

    always_comb begin
        psc_hit = 1'b1;
        case (psc_sel_q)
            2'b00:   psc_hit = 1'b1;
            2'b01:   psc_hit = &pre_q[3:0];
            2'b10:   psc_hit = &pre_q[7:0];
            default: psc_hit = &pre_q;
        endcase
    end

    // Tick uses pre-write CTRL; a RELOAD_HI write suppresses the tick's effect.
    assign tick   = en_q & psc_hit;
    assign expire = tick & ~wr_hi & (count_q == 16'd0);

    always_comb begin
        count_d = count_q;
        if (wr_hi) begin
            count_d = {din, reload_q[7:0]};
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end else begin
                count_d = 16'd0;
            end
        end
    end

    always_comb begin
        en_d = en_q;
        if (wr_ctrl) begin
            en_d = din[0];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end
    end

    always_comb begin
        pre_d = pre_q + 12'd1;
        if (wr_hi || !en_q) begin
            pre_d = 12'd0;
        end
    end

    // Expiry wins over a same-edge W1C clear.
    always_comb begin
        flag_d = flag_q;
        if (expire) begin
            flag_d = 1'b1;
        end else if (wr_stat && din[0]) begin
            flag_d = 1'b0;
        end
    end

    assign ie_d = wr_ctrl ? din[2] : ie_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            reload_q  <= 16'd0;
            count_q   <= 16'd0;
            snap_q    <= 8'd0;
            en_q      <= 1'b0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            psc_sel_q <= 2'b00;
            pre_q     <= 12'd0;
            flag_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_lo) begin
                reload_q[7:0] <= din;
            end
            if (wr_hi) begin
                reload_q[15:8] <= din;
            end
            if (rd_count_lo) begin
                snap_q <= count_q[15:8];
            end
            if (wr_ctrl) begin
                auto_q    <= din[1];
                psc_sel_q <= din[5:4];
            end
            count_q <= count_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            pre_q   <= pre_d;
            flag_q  <= flag_d;
            irq_q   <= flag_d & ie_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        dout = 8'h00;
        case (addr)
            ADDR_RELOAD_LO: dout = reload_q[7:0];
            ADDR_RELOAD_HI: dout = reload_q[15:8];
            ADDR_COUNT_LO:  dout = count_q[7:0];
            ADDR_COUNT_HI:  dout = snap_q;
            ADDR_CTRL:      dout = {2'b00, psc_sel_q, 1'b0, ie_q, auto_q, en_q};
            ADDR_STATUS:    dout = {7'd0, flag_q};
            default:        dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_timer_io_8.sv
// Bench for timer_io_8: a register-level reference model predicts dout/irq for
// every bus cycle; a negedge monitor pops predictions and compares them.
module tb_timer_io_8;

    logic       clk;
    logic       reset_;
    logic       cs;
    logic [2:0] addr;
    logic [7:0] din;
    logic       we;
    logic [7:0] dout;
    logic       irq;

    timer_io_8 dut (
        .clk    (clk),
        .reset_ (reset_),
        .cs     (cs),
        .addr   (addr),
        .din    (din),
        .we     (we),
        .dout   (dout),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct packed {
        logic [7:0] dout;
        logic       irq;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // Reference model state, kept as plain integers.
    int m_reload, m_count, m_snap, m_pre, m_psc;
    bit m_en, m_auto, m_ie, m_flag;

    task automatic model_reset();
        m_reload = 0; m_count = 0; m_snap = 0; m_pre = 0; m_psc = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_flag = 0;
    endtask

    function automatic exp_t model_out(int a);
        exp_t e;
        int   v;
        case (a)
            0: v = m_reload % 256;
            1: v = m_reload / 256;
            2: v = m_count % 256;
            3: v = m_snap;
            4: v = int'(m_en) + 2 * int'(m_auto) + 4 * int'(m_ie) + 16 * m_psc;
            5: v = int'(m_flag);
            default: v = 0;
        endcase
        e.dout = 8'(v);
        e.irq  = m_flag && m_ie;
        return e;
    endfunction

    task automatic model_edge(bit rst, bit c, bit w, int a, int d);
        int div, n_count, n_pre;
        bit tick, hi_wr, expired, n_en, n_flag;
        if (rst) begin
            model_reset();
            return;
        end
        div     = 1 << (4 * m_psc);
        tick    = m_en && ((m_pre % div) == div - 1);
        hi_wr   = c && w && (a == 1);
        n_count = m_count;
        n_en    = m_en;
        n_flag  = m_flag;
        n_pre   = m_en ? (m_pre + 1) % 4096 : 0;
        expired = 0;
        if (tick && !hi_wr) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                expired = 1;
                if (m_auto) n_count = m_reload;
                else begin
                    n_count = 0;
                    n_en    = 0;
                end
            end
        end
        if (c && !w && a == 2) m_snap = m_count / 256;
        if (c && w) begin
            case (a)
                0: m_reload = (m_reload / 256) * 256 + d;
                1: begin
                    m_reload = d * 256 + m_reload % 256;
                    n_count  = m_reload;
                    n_pre    = 0;
                end
                4: begin
                    n_en   = (d & 1) != 0;
                    m_auto = (d & 2) != 0;
                    m_ie   = (d & 4) != 0;
                    m_psc  = (d >> 4) & 3;
                end
                5: if ((d & 1) != 0) n_flag = 0;
                default: ;
            endcase
        end
        if (expired) n_flag = 1;
        m_count = n_count;
        m_en    = n_en;
        m_flag  = n_flag;
        m_pre   = n_pre;
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one prediction per bus cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (dout !== e.dout) begin
                failures++;
                $display("FAIL %s dout actual=%02h required=%02h", t, dout, e.dout);
            end
            checks++;
            if (irq !== e.irq) begin
                failures++;
                $display("FAIL %s irq actual=%0b required=%0b", t, irq, e.irq);
            end
        end
    end

    task automatic op(bit rst, bit c, bit w, int a, int d, string tag);
        @(posedge clk);
        #1;
        reset_ = !rst;
        cs     = c;
        we     = w;
        addr   = 3'(a);
        din    = 8'(d);
        if (rst) model_reset();
        exp_q.push_back(model_out(a));
        tag_q.push_back(tag);
        model_edge(rst, c, w, a, d);
    endtask

    task automatic wr(int a, int d, string tag);
        op(0, 1, 1, a, d, tag);
    endtask

    task automatic idle();
        op(0, 0, 0, int'($urandom_range(0, 7)), 0, "idle");
    endtask

    task automatic rd_chk(int a, int req, string name);
        op(0, 1, 0, a, 0, name);
        #1;
        chk(name, int'(dout), req);
    endtask

    task automatic wait_irq(bit level, int budget, string name, output int at);
        int n = 0;
        while (irq !== level && n < budget) begin
            idle();
            n++;
        end
        at = edge_n;
        chk({name, "_bound"}, int'(irq), int'(level));
    endtask

    initial begin
        int n, t1, t2, r, a, d;
        reset_ = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'd0;
        model_reset();

        for (int i = 0; i < 8; i++) op(1, 1, 0, i, 0, "reset_state");
        op(0, 0, 0, 0, 0, "reset_release");

        // One-shot: flag on the 4th clk after the CTRL write.
        wr(0, 3, "os_lo"); wr(1, 0, "os_hi"); wr(4, 8'h05, "os_ctrl");
        idle();
        n = 0;
        while (irq !== 1'b1 && n < 20) begin
            idle();
            n++;
        end
        chk("oneshot_latency", n, 4);
        rd_chk(4, 8'h04, "oneshot_en_cleared");
        rd_chk(2, 8'h00, "oneshot_count_zero");
        rd_chk(5, 8'h01, "oneshot_status");

        // Periodic with PSC=01 and AUTO: 32 clks between flags.
        wr(5, 1, "per_clr"); wr(0, 1, "per_lo"); wr(1, 0, "per_hi"); wr(4, 8'h17, "per_ctrl");
        wait_irq(1, 100, "per_first", t1);
        wr(5, 1, "per_w1c");
        idle();
        chk("w1c_drop_irq", int'(irq), 0);
        wait_irq(1, 100, "per_second", t2);
        chk("period_clks", t2 - t1, 32);

        // W1C on the exact expiry edge, then RELOAD_HI on an expiry edge.
        wr(4, 0, "se_stop"); wr(5, 1, "se_clr"); wr(0, 2, "se_lo"); wr(1, 0, "se_hi");
        wr(4, 8'h07, "se_ctrl");
        idle(); idle();
        wr(5, 1, "se_w1c_on_expiry");
        rd_chk(5, 8'h01, "w1c_same_edge_status");
        chk("w1c_same_edge_irq", int'(irq), 1);
        wr(5, 1, "se_clr2");
        wr(1, 8'h12, "se_hi_on_expiry");
        rd_chk(2, 8'h02, "hi_wr_count_lo");
        rd_chk(3, 8'h12, "hi_wr_count_hi");
        rd_chk(5, 8'h00, "hi_wr_no_flag");
        wr(4, 0, "se_stop2");

        // Snapshot coherency across the 0x0100 -> 0x00FF roll.
        wr(0, 0, "sn_lo"); wr(1, 1, "sn_hi"); wr(4, 8'h01, "sn_ctrl");
        rd_chk(2, 8'h00, "snap_count_lo");
        rd_chk(3, 8'h01, "snap_count_hi");
        rd_chk(2, 8'hFE, "snap_count_moved");
        wr(4, 0, "sn_stop");

        // Reset in the middle of a count with irq asserted.
        wr(0, 0, "rm_lo"); wr(1, 0, "rm_hi"); wr(4, 8'h05, "rm_expire");
        idle(); idle();
        wr(1, 8'h08, "rm_hi_0800"); wr(4, 8'h05, "rm_run");
        idle(); idle();
        chk("pre_reset_irq", int'(irq), 1);
        for (int i = 0; i < 8; i++) begin
            op(1, 1, 0, i, 0, "rst_mid");
            #1;
            chk("rst_mid_dout", int'(dout), 0);
            chk("rst_mid_irq", int'(irq), 0);
        end
        op(0, 0, 0, 0, 0, "rst_mid_release");
        wr(0, 5, "pr_lo"); wr(1, 0, "pr_hi");
        repeat (10) idle();
        rd_chk(2, 8'h05, "no_tick_after_reset");
        rd_chk(5, 8'h00, "no_flag_after_reset");
        rd_chk(4, 8'h00, "ctrl_after_reset");

        // Decode: cs=0 writes are ignored; offsets 6/7 and reserved bits read 0.
        for (int i = 0; i < 8; i++) op(0, 0, 1, i, int'($urandom_range(0, 255)), "cs0_write");
        rd_chk(0, 8'h05, "dec_reload_lo");
        rd_chk(1, 8'h00, "dec_reload_hi");
        rd_chk(2, 8'h05, "dec_count_lo");
        rd_chk(4, 8'h00, "dec_ctrl");
        rd_chk(5, 8'h00, "dec_status");
        wr(6, 8'hFF, "wr6"); wr(7, 8'hFF, "wr7");
        rd_chk(6, 8'h00, "dec_off6");
        rd_chk(7, 8'h00, "dec_off7");
        wr(4, 8'hF8, "ctrl_reserved");
        rd_chk(4, 8'h30, "ctrl_reserved_read");
        wr(4, 0, "ctrl_clear");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            a = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 255));
            if (r < 80) idle();
            else if (r < 120) op(0, 1, 0, a, 0, "rnd_read");
            else if (r < 180) begin
                if (a == 4) d = (d & 8'hCF) | (($urandom_range(0, 3) == 0) ? 8'h10 : 8'h00);
                if (a == 0) d = d & 8'h07;
                if (a == 1) d = ($urandom_range(0, 3) == 0) ? d : 0;
                op(0, 1, 1, a, d, "rnd_write");
            end else if (r < 198) wr(4, ($urandom_range(0, 1) == 1) ? 8'h07 : 8'h05, "rnd_enable");
            else op(1, 0, 0, a, 0, "rnd_reset");
        end

        idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_io_8.md
TIMER_IO_8 -- requirements
Module: timer_io_8

Interface
REQ-001 SHALL have no parameters; register map and widths are fixed.
REQ-002 SHALL have port clk, input, 1, system clock; every register updates on its rising edge.
REQ-003 SHALL have port reset_, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cs, input, 1, chip select from the system address decode (0x21xx page).
REQ-005 SHALL have port addr, input, 3, register offset (CPU address bits [2:0]).
REQ-006 SHALL have port din, input, 8, CPU write data.
REQ-007 SHALL have port we, input, 1, write strobe (active high, the inverse of CPU rdwr_).
REQ-008 SHALL have port dout, output, 8, read data, combinational from addr and registers.
REQ-009 SHALL have port irq, output, 1, interrupt request to the CPU, active high.

Function
REQ-010 SHALL use this register map:
- 0: RELOAD_LO, R/W.
- 1: RELOAD_HI, R/W.
- 2: COUNT_LO, R.
- 3: COUNT_HI, R, returns the snapshot.
- 4: CTRL, R/W.
- 5: STATUS, R / W1C.
- 6, 7: read 0x00, writes ignored.
REQ-011 SHALL define CTRL bits: [0] EN, [1] AUTO, [2] IE, [5:4] PSC, [7:6] and [3] read 0.
REQ-012 SHALL accept a write only on a clk edge with cs=1 and we=1.
REQ-013 SHALL treat a cycle with cs=1 and we=0 as a read; only offset 2 has a read side effect.
REQ-014 SHALL, on a read of offset 2, latch count[15:8] into a snapshot register at that clk edge; offset 3 returns the snapshot.
REQ-015 SHALL, on a write to RELOAD_HI, set count to {din, RELOAD_LO} and clear the prescaler on the same edge.
REQ-016 SHALL run a 12-bit prescaler that increments each clk while EN=1 and holds at 0 while EN=0.
REQ-017 SHALL assert an internal tick when EN=1 and, per PSC: 00 every clk; 01 when psc[3:0]=0xF; 10 when psc[7:0]=0xFF; 11 when psc[11:0]=0xFFF.
REQ-018 SHALL, on a tick with count != 0, decrement count by 1.
REQ-019 SHALL, on a tick with count = 0:
- set STATUS[0];
- if AUTO=1, load count with RELOAD;
- if AUTO=0, clear EN and hold count at 0.
REQ-020 SHALL therefore produce a period of (RELOAD+1) ticks; RELOAD=0 with AUTO=1 sets the flag on every tick.
REQ-021 SHALL clear STATUS[0] on a write to offset 5 with din[0]=1; din[0]=0 has no effect.
REQ-022 SHALL give set priority when an expiry and a W1C clear occur on the same edge (STATUS[0] ends at 1).
REQ-023 SHALL give a RELOAD_HI write priority over a same-edge tick: count takes the written value, with no decrement and no expiry.
REQ-024 SHALL apply a CTRL write on the edge it occurs; a tick on that same edge is evaluated with the pre-write EN, AUTO and PSC.
REQ-025 SHALL drive irq = STATUS[0] AND IE, computed from flops only and glitch-free.
REQ-026 SHALL keep reading STATUS[0] as 1 while IE=0; irq asserts as soon as IE is written to 1.
REQ-027 SHALL perform count arithmetic in 16 bits unsigned with no underflow; expiry reloads or stops the counter.

Reset
REQ-028 SHALL, while reset_=0, hold RELOAD, count, snapshot, CTRL, prescaler and STATUS at 0.
REQ-029 SHALL, while reset_=0, drive irq=0 and dout=0x00 for every offset.
REQ-030 SHALL abort any count in progress on reset, including mid-period, with no pending flag after release.
REQ-031 SHALL start the first post-reset prescaler cycle only after EN is written to 1.

Verification
REQ-032 One-shot: RELOAD=0x0003, CTRL=0x05 (EN, IE, PSC=00) -> STATUS[0] and irq rise on the 4th clk after the CTRL write; EN reads 0 afterwards; count stays 0x0000.
REQ-033 Periodic, prescaled: RELOAD=0x0001, CTRL=0x17 (PSC=01, AUTO) -> a flag every 32 clks; W1C 0x01 drops irq within 1 clk; the flag re-sets 32 clks after the previous set.
REQ-034 Same-edge conflict: W1C on the exact expiry edge -> STATUS=0x01, irq stays 1; a RELOAD_HI=0x12 write on a tick edge -> count=0x12xx, no flag.
REQ-035 Snapshot coherency: count at 0x0100 with PSC=00 -> read COUNT_LO then COUNT_HI gives 0x00/0x01 while count has since rolled to 0x00FF.
REQ-036 Reset mid-count: reset_ pulsed low at count=0x0800 with irq=1 -> all reads 0x00 and irq=0 immediately (asynchronous); no tick until CTRL is rewritten.
REQ-037 Decode: cs=0 with we=1 to each offset -> no register changes; offsets 6 and 7 read 0x00; CTRL reserved bits read 0.
